// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU control sequencer: opcode encodings, ALU
// operation codes, FSM state encoding, instruction classes and the PC /
// write-back mux select codes.
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

   localparam int OPCODE_W = 4;

   // Opcode encodings
   localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b0000;
   localparam logic [OPCODE_W-1:0] OP_ST   = 4'b0011;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0100;
   localparam logic [OPCODE_W-1:0] OP_INC  = 4'b0101;
   localparam logic [OPCODE_W-1:0] OP_NEG  = 4'b0110;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0111;
   localparam logic [OPCODE_W-1:0] OP_J    = 4'b1000;
   localparam logic [OPCODE_W-1:0] OP_BRZ  = 4'b1001;
   localparam logic [OPCODE_W-1:0] OP_JM   = 4'b1010;
   localparam logic [OPCODE_W-1:0] OP_BRN  = 4'b1011;
   localparam logic [OPCODE_W-1:0] OP_LD   = 4'b1110;
   localparam logic [OPCODE_W-1:0] OP_SVPC = 4'b1111;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_INC  = 3'b010;
   localparam logic [2:0] ALU_NEG  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b000;
   localparam logic [2:0] ALU_PASS = 3'b111;

   // PC source select
   localparam logic [1:0] PC_SEL_NEXT = 2'b00;
   localparam logic [1:0] PC_SEL_REG  = 2'b01;
   localparam logic [1:0] PC_SEL_MEM  = 2'b10;

   // Register write-back source select
   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC  = 2'b10;

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_EXEC  = 2'b01,
      ST_MEM   = 2'b10,
      ST_WB    = 2'b11
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOP    = 3'd0,
      CLS_ALU    = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_JMEM   = 3'd4,
      CLS_JUMP   = 3'd5,
      CLS_BRANCH = 3'd6,
      CLS_SVPC   = 3'd7
   } op_class_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational opcode decoder.
//   opcode  in   registered opcode
//   aluop   out  ALU operation used during EXEC
//   cls     out  instruction class steering the sequencer
//   illegal out  opcode is undefined (decoded as NOP)
// -----------------------------------------------------------------------------
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output logic [2:0]          aluop,
   output op_class_t           cls,
   output logic                illegal
);

   always_comb begin
      aluop   = ALU_PASS;
      cls     = CLS_NOP;
      illegal = 1'b0;
      unique case (opcode)
         OP_NOP:  cls = CLS_NOP;
         OP_ADD:  begin cls = CLS_ALU; aluop = ALU_ADD; end
         OP_INC:  begin cls = CLS_ALU; aluop = ALU_INC; end
         OP_NEG:  begin cls = CLS_ALU; aluop = ALU_NEG; end
         OP_SUB:  begin cls = CLS_ALU; aluop = ALU_SUB; end
         OP_LD:   cls = CLS_LOAD;
         OP_ST:   cls = CLS_STORE;
         OP_JM:   cls = CLS_JMEM;
         OP_J:    cls = CLS_JUMP;
         OP_BRZ,
         OP_BRN:  cls = CLS_BRANCH;
         OP_SVPC: cls = CLS_SVPC;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_control_fsm.sv
// -----------------------------------------------------------------------------
// alu_control_fsm
// Multi-cycle FETCH/EXEC/MEM/WB sequencer driving the ALU op-select, register
// file, data memory and PC, and holding the architectural Z/N flags.
//   clk, rst_n        clock, asynchronous active-low reset
//   in_instr_valid    opcode offered by fetch
//   out_instr_ready   opcode accepted (FETCH only)
//   in_opcode         opcode, captured on valid & ready
//   in_alu_zero/neg   ALU flags, latched when an ALU op leaves EXEC
//   out_ctrl_aluop    ALU operation (pass outside EXEC)
//   out_reg_write, out_mem_read, out_mem_write, out_pc_write   strobes
//   out_pc_sel, out_wb_sel   mux selects
//   out_flag_z/n      architectural flags
//   out_illegal       one-cycle pulse in EXEC of an undefined opcode
// All outputs depend only on state, registered opcode and registered flags.
// -----------------------------------------------------------------------------
module alu_control_fsm
   import alu_ctrl_pkg::*;
#(
   parameter int OPW = OPCODE_W
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_instr_valid,
   output logic           out_instr_ready,
   input  logic [OPW-1:0] in_opcode,
   input  logic           in_alu_zero,
   input  logic           in_alu_neg,
   output logic [2:0]     out_ctrl_aluop,
   output logic           out_reg_write,
   output logic           out_mem_read,
   output logic           out_mem_write,
   output logic           out_pc_write,
   output logic [1:0]     out_pc_sel,
   output logic [1:0]     out_wb_sel,
   output logic           out_flag_z,
   output logic           out_flag_n,
   output logic           out_illegal
);

   state_t          state, state_nxt;
   logic [OPW-1:0]  opcode_q;
   logic            flag_z_q, flag_n_q;
   logic [2:0]      dec_aluop;
   op_class_t       dec_cls;
   logic            dec_illegal;
   logic            branch_taken;

   alu_ctrl_decode u_decode (
      .opcode  (opcode_q),
      .aluop   (dec_aluop),
      .cls     (dec_cls),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_FETCH;
         opcode_q <= OP_NOP;
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_FETCH && in_instr_valid)
            opcode_q <= in_opcode;
         // Flags only move when an ALU op leaves EXEC.
         if (state == ST_EXEC && dec_cls == CLS_ALU) begin
            flag_z_q <= in_alu_zero;
            flag_n_q <= in_alu_neg;
         end
      end
   end

   // BRZ and BRN differ only in which registered flag they test.
   assign branch_taken = (opcode_q == OP_BRN) ? flag_n_q : flag_z_q;

   always_comb begin
      state_nxt      = state;
      out_ctrl_aluop = ALU_PASS;
      out_reg_write  = 1'b0;
      out_mem_read   = 1'b0;
      out_mem_write  = 1'b0;
      out_pc_write   = 1'b0;
      out_pc_sel     = PC_SEL_NEXT;
      out_wb_sel     = WB_SEL_ALU;
      out_illegal    = 1'b0;
      unique case (state)
         ST_FETCH: begin
            if (in_instr_valid)
               state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            out_ctrl_aluop = dec_aluop;
            unique case (dec_cls)
               CLS_ALU, CLS_SVPC:           state_nxt = ST_WB;
               CLS_LOAD, CLS_STORE, CLS_JMEM: state_nxt = ST_MEM;
               CLS_JUMP: begin
                  out_pc_sel   = PC_SEL_REG;
                  out_pc_write = 1'b1;
                  state_nxt    = ST_FETCH;
               end
               CLS_BRANCH: begin
                  out_pc_sel   = branch_taken ? PC_SEL_REG : PC_SEL_NEXT;
                  out_pc_write = 1'b1;
                  state_nxt    = ST_FETCH;
               end
               default: begin
                  out_illegal  = dec_illegal;
                  out_pc_write = 1'b1;
                  state_nxt    = ST_FETCH;
               end
            endcase
         end
         ST_MEM: begin
            unique case (dec_cls)
               CLS_LOAD: begin
                  out_mem_read = 1'b1;
                  state_nxt    = ST_WB;
               end
               CLS_STORE: begin
                  out_mem_write = 1'b1;
                  out_pc_write  = 1'b1;
                  state_nxt     = ST_FETCH;
               end
               default: begin
                  out_mem_read = 1'b1;
                  out_pc_sel   = PC_SEL_MEM;
                  out_pc_write = 1'b1;
                  state_nxt    = ST_FETCH;
               end
            endcase
         end
         default: begin
            out_reg_write = 1'b1;
            out_pc_write  = 1'b1;
            state_nxt     = ST_FETCH;
            if (dec_cls == CLS_LOAD)
               out_wb_sel = WB_SEL_MEM;
            else if (dec_cls == CLS_SVPC)
               out_wb_sel = WB_SEL_PC;
         end
      endcase
   end

   // Ready is masked by rst_n so fetch never sees a handshake during reset.
   assign out_instr_ready = rst_n && (state == ST_FETCH);
   assign out_flag_z      = flag_z_q;
   assign out_flag_n      = flag_n_q;

endmodule

// File: tb/tb_alu_control_fsm.sv
module tb_alu_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_instr_valid;
   logic       out_instr_ready;
   logic [3:0] in_opcode;
   logic       in_alu_zero;
   logic       in_alu_neg;
   logic [2:0] out_ctrl_aluop;
   logic       out_reg_write;
   logic       out_mem_read;
   logic       out_mem_write;
   logic       out_pc_write;
   logic [1:0] out_pc_sel;
   logic [1:0] out_wb_sel;
   logic       out_flag_z;
   logic       out_flag_n;
   logic       out_illegal;

   int checks = 0;
   int errors = 0;

   alu_control_fsm dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_instr_valid  (in_instr_valid),
      .out_instr_ready (out_instr_ready),
      .in_opcode       (in_opcode),
      .in_alu_zero     (in_alu_zero),
      .in_alu_neg      (in_alu_neg),
      .out_ctrl_aluop  (out_ctrl_aluop),
      .out_reg_write   (out_reg_write),
      .out_mem_read    (out_mem_read),
      .out_mem_write   (out_mem_write),
      .out_pc_write    (out_pc_write),
      .out_pc_sel      (out_pc_sel),
      .out_wb_sel      (out_wb_sel),
      .out_flag_z      (out_flag_z),
      .out_flag_n      (out_flag_n),
      .out_illegal     (out_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Packed strobe vector: {reg_write, mem_read, mem_write, pc_write, illegal}
   function automatic logic [7:0] strobes();
      return {3'b000, out_reg_write, out_mem_read, out_mem_write, out_pc_write, out_illegal};
   endfunction

   // Present an opcode in FETCH and move into EXEC; fetch then scribbles in_opcode.
   task automatic issue(input logic [3:0] op, input string tag);
      check({tag, "_ready"}, {7'b0, out_instr_ready}, 8'h01);
      in_instr_valid = 1'b1;
      in_opcode      = op;
      step();
      in_instr_valid = 1'b0;
      in_opcode      = 4'b1101;
   endtask

   initial begin
      rst_n          = 1'b0;
      in_instr_valid = 1'b0;
      in_opcode      = 4'b0000;
      in_alu_zero    = 1'b0;
      in_alu_neg     = 1'b0;
      #2;
      check("rst_ready", {7'b0, out_instr_ready}, 8'h00);
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("idle_ready",   {7'b0, out_instr_ready}, 8'h01);
      check("idle_strobes", strobes(), 8'h00);
      check("idle_aluop",   {5'b0, out_ctrl_aluop}, 8'h07);
      check("idle_flags",   {6'b0, out_flag_z, out_flag_n}, 8'h00);

      // ADD, zero=1 neg=0
      in_alu_zero = 1'b1; in_alu_neg = 1'b0;
      issue(4'b0100, "add");
      check("add_exec_aluop",   {5'b0, out_ctrl_aluop}, 8'h04);
      check("add_exec_strobes", strobes(), 8'h00);
      step();
      in_alu_zero = 1'b0; in_alu_neg = 1'b1;   // must not reach flags outside EXEC
      check("add_wb_strobes", strobes(), 8'h12);
      check("add_wb_sel",     {6'b0, out_wb_sel}, 8'h00);
      check("add_wb_aluop",   {5'b0, out_ctrl_aluop}, 8'h07);
      step();
      check("add_done_ready", {7'b0, out_instr_ready}, 8'h01);
      check("add_flags",      {6'b0, out_flag_z, out_flag_n}, 8'h02);

      // SUB neg=1, then BRN taken
      in_alu_zero = 1'b0; in_alu_neg = 1'b1;
      issue(4'b0111, "sub1");
      check("sub1_exec_aluop", {5'b0, out_ctrl_aluop}, 8'h00);
      step(); step();
      check("sub1_flags", {6'b0, out_flag_z, out_flag_n}, 8'h01);
      in_alu_neg = 1'b0;
      issue(4'b1011, "brn1");
      check("brn1_pc_sel",  {6'b0, out_pc_sel}, 8'h01);
      check("brn1_strobes", strobes(), 8'h02);
      step();
      check("brn1_ready", {7'b0, out_instr_ready}, 8'h01);
      check("brn1_flags", {6'b0, out_flag_z, out_flag_n}, 8'h01);

      // SUB neg=0, then BRN not taken
      in_alu_zero = 1'b0; in_alu_neg = 1'b0;
      issue(4'b0111, "sub0");
      step(); step();
      check("sub0_flags", {6'b0, out_flag_z, out_flag_n}, 8'h00);
      issue(4'b1011, "brn0");
      check("brn0_pc_sel",  {6'b0, out_pc_sel}, 8'h00);
      check("brn0_strobes", strobes(), 8'h02);
      step();

      // Set both flags, then LD / JM must leave them alone
      in_alu_zero = 1'b1; in_alu_neg = 1'b1;
      issue(4'b0101, "inc");
      check("inc_exec_aluop", {5'b0, out_ctrl_aluop}, 8'h02);
      step(); step();
      check("inc_flags", {6'b0, out_flag_z, out_flag_n}, 8'h03);
      in_alu_zero = 1'b0; in_alu_neg = 1'b0;
      issue(4'b1110, "ld");
      check("ld_exec_aluop",   {5'b0, out_ctrl_aluop}, 8'h07);
      check("ld_exec_strobes", strobes(), 8'h00);
      step();
      check("ld_mem_strobes", strobes(), 8'h08);
      step();
      check("ld_wb_strobes", strobes(), 8'h12);
      check("ld_wb_sel",     {6'b0, out_wb_sel}, 8'h01);
      step();
      check("ld_done_ready", {7'b0, out_instr_ready}, 8'h01);
      check("ld_flags",      {6'b0, out_flag_z, out_flag_n}, 8'h03);

      issue(4'b1010, "jm");
      check("jm_exec_aluop", {5'b0, out_ctrl_aluop}, 8'h07);
      step();
      check("jm_mem_strobes", strobes(), 8'h0a);
      check("jm_mem_pc_sel",  {6'b0, out_pc_sel}, 8'h02);
      step();
      check("jm_done_ready", {7'b0, out_instr_ready}, 8'h01);
      check("jm_flags",      {6'b0, out_flag_z, out_flag_n}, 8'h03);

      // ST and SVPC
      issue(4'b0011, "st");
      step();
      check("st_mem_strobes", strobes(), 8'h06);
      check("st_mem_pc_sel",  {6'b0, out_pc_sel}, 8'h00);
      step();
      issue(4'b1111, "svpc");
      check("svpc_exec_aluop", {5'b0, out_ctrl_aluop}, 8'h07);
      step();
      check("svpc_wb_strobes", strobes(), 8'h12);
      check("svpc_wb_sel",     {6'b0, out_wb_sel}, 8'h02);
      step();

      // BRZ taken (flag_z still 1) and plain J
      issue(4'b1001, "brz");
      check("brz_pc_sel", {6'b0, out_pc_sel}, 8'h01);
      step();
      issue(4'b1000, "j");
      check("j_pc_sel",  {6'b0, out_pc_sel}, 8'h01);
      check("j_strobes", strobes(), 8'h02);
      step();

      // Undefined opcode
      issue(4'b1100, "ill");
      check("ill_exec_strobes", strobes(), 8'h03);
      check("ill_exec_pc_sel",  {6'b0, out_pc_sel}, 8'h00);
      step();
      check("ill_done_strobes", strobes(), 8'h00);
      check("ill_done_ready",   {7'b0, out_instr_ready}, 8'h01);

      // Reset during LD MEM
      issue(4'b1110, "ldrst");
      step();
      check("ldrst_mem_read", strobes(), 8'h08);
      #2;
      rst_n = 1'b0;
      #1;
      check("ldrst_strobes", strobes(), 8'h00);
      check("ldrst_ready",   {7'b0, out_instr_ready}, 8'h00);
      check("ldrst_flags",   {6'b0, out_flag_z, out_flag_n}, 8'h00);
      check("ldrst_aluop",   {5'b0, out_ctrl_aluop}, 8'h07);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_rst_ready",   {7'b0, out_instr_ready}, 8'h01);
      check("post_rst_strobes", strobes(), 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_control_fsm.md
# alu_control_fsm

Multi-cycle control sequencer that drives the ALU's operation-select interface and consumes its zero/negative flags. It sits between instruction fetch and the datapath. It accepts one 4-bit opcode per instruction through a valid/ready handshake and steps it through EXEC/MEM/WB. It emits ALU op codes, register/memory/PC strobes and mux selects, and keeps architectural Z/N flags for conditional branches.

## Interface
- OPW, 4, opcode width (fixed ISA; not meant to be overridden)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_instr_valid  in  1  fetch stage presents an opcode
- out_instr_ready  out  1  controller accepts an opcode (FETCH state)
- in_opcode  in  OPW  opcode, sampled on valid & ready
- in_alu_zero  in  1  ALU zero flag (combinational from ALU)
- in_alu_neg  in  1  ALU negative flag
- out_ctrl_aluop  out  3  ALU op: 100 add, 010 inc, 001 neg, 000 sub, 111 pass
- out_reg_write  out  1  register-file write strobe
- out_mem_read / out_mem_write  out  1  data-memory strobes
- out_pc_write  out  1  PC update strobe
- out_pc_sel  out  2  00 PC+1, 01 register target, 10 memory target
- out_wb_sel  out  2  00 ALU result, 01 memory data, 10 PC
- out_flag_z / out_flag_n  out  1  architectural flags
- out_illegal  out  1  one-cycle pulse on undefined opcode

## Operation
- Opcodes: 0000 NOP, 1111 SVPC, 1110 LD, 0011 ST, 0100 ADD, 0101 INC, 0110 NEG, 0111 SUB, 1000 J, 1001 BRZ, 1010 JM, 1011 BRN. Undefined: 0001, 0010, 1100, 1101.
- States: FETCH, EXEC, MEM, WB. Opcode is registered on handshake, FETCH -> EXEC.
- EXEC, ADD/INC/NEG/SUB: aluop per the table above, then -> WB. Z/N registers load in_alu_zero/in_alu_neg at the edge leaving EXEC. No other opcode touches the flags.
- EXEC, LD/ST/JM: aluop 111 (address pass), then -> MEM.
- EXEC, SVPC: aluop 111, then -> WB.
- EXEC, J: pc_sel 01, pc_write, then -> FETCH.
- EXEC, BRZ/BRN: pc_sel 01 if the registered flag_z/flag_n is set, else 00. pc_write asserted. Then -> FETCH.
- EXEC, NOP: pc_sel 00, pc_write, then -> FETCH.
- EXEC, undefined opcode: out_illegal pulse, behaves as NOP.
- MEM, LD: mem_read, then -> WB.
- MEM, ST: mem_write, pc_sel 00, pc_write, then -> FETCH.
- MEM, JM: mem_read, pc_sel 10, pc_write, then -> FETCH.
- WB: reg_write. wb_sel 00 for ALU ops, 01 for LD, 10 for SVPC. pc_sel 00, pc_write, then -> FETCH.
- Outputs are combinational from state and the registered opcode only. in_opcode never drives outputs directly.
- Outside EXEC, out_ctrl_aluop = 111, so the ALU holds its flags.

## Timing
- Reset (async assert, sync release): state FETCH, opcode reg 0000, flag_z = flag_n = 0.
- Reset values of outputs: all strobes 0, aluop 111, pc_sel 00, wb_sel 00, illegal 0.
- out_instr_ready is forced 0 while rst_n is low and goes to 1 in the first cycle after release.
- Cycles per instruction, including FETCH: ALU ops 3, LD 4, ST 3, JM 3, SVPC 3, J/BRZ/BRN/NOP/illegal 2. Handshake is 1 cycle minimum.
- FETCH with valid low: stay in FETCH, all strobes 0.
- out_instr_ready is low in EXEC/MEM/WB. in_opcode changes there are ignored.
- Branch following an ALU op: the branch sees the flags written at that ALU op's EXEC exit (no forwarding hazard, since they are two separate instructions).
- Reset mid-instruction: immediate return to FETCH, flags cleared, no further strobes.

## Structure
- Package alu_ctrl_pkg holds:
  - opcode localparams;
  - aluop codes (ALU_ADD, ALU_INC, ALU_NEG, ALU_SUB, ALU_PASS);
  - state encoding;
  - pc_sel and wb_sel codes.
- One combinational sub-module, alu_ctrl_decode: registered opcode -> {aluop, class (alu/load/store/jmem/jump/branch/svpc/nop), illegal}.
- The FSM and flag registers live in alu_control_fsm.

## Test plan
- Reset release, valid = 0 for 5 cycles -> ready = 1, all strobes 0, aluop 111, flags 0.
- ADD with in_alu_zero = 1, in_alu_neg = 0:
  - EXEC aluop 100;
  - WB reg_write = 1, wb_sel 00, pc_write;
  - then flag_z = 1, flag_n = 0, and total 3 cycles.
- SUB with neg = 1, then BRN -> BRN EXEC asserts pc_sel 01 and pc_write.
- SUB with neg = 0, then BRN -> BRN EXEC asserts pc_sel 00.
- LD -> mem_read in cycle 3, reg_write + wb_sel 01 in cycle 4. JM -> mem_read + pc_sel 10 in cycle 3. Neither changes the flags.
- Opcode 1100 -> out_illegal single pulse, pc_sel 00, back in FETCH after 2 cycles.
- rst_n pulsed low during LD MEM -> strobes drop immediately, state FETCH, flags 0.
